// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   localparam logic REQ_I = 1'b0;
   localparam logic REQ_D = 1'b1;

   // Counter holds LATENCY-1, so this bounds the supported access window.
   localparam int unsigned MAX_LATENCY = 256;
   localparam int unsigned CNT_W       = $clog2(MAX_LATENCY);

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU fetch/data ports, memory-side bus and status of the arbiter in one bundle.
interface mem_arbiter_if #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DATA_W = 16
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_ready;
   logic [DATA_W-1:0] i_data;

   logic              d_req;
   logic              d_wr;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ready;
   logic [DATA_W-1:0] d_rdata;

   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_enable;
   logic              mem_wr;
   logic [DATA_W-1:0] mem_rdata;

   logic              busy;

   modport slave (
      input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
      output i_ready, i_data, d_ready, d_rdata,
             mem_addr, mem_wdata, mem_enable, mem_wr, busy
   );

   modport master (
      output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
      input  i_ready, i_data, d_ready, d_rdata,
             mem_addr, mem_wdata, mem_enable, mem_wr, busy
   );

endinterface

// File: rtl/mem_arb_grant.sv
// Grant selection between fetch and data requesters.
// MEM_ARB_RR_EN: round-robin on ties with a last-grant pointer; otherwise D over I.
module mem_arb_grant
   import mem_arb_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_req,
   input  logic d_req,
   input  logic take,
   output logic gnt
);

`ifdef MEM_ARB_RR_EN
   logic last;

   always_ff @(posedge clk) begin
      if (rst) begin
         last <= REQ_I;
      end else if (take) begin
         last <= gnt;
      end
   end

   always_comb begin
      gnt = REQ_D;
      if (i_req && d_req) begin
         gnt = (last == REQ_I) ? REQ_D : REQ_I;
      end else if (i_req) begin
         gnt = REQ_I;
      end
   end
`else
   logic unused_ok;

   assign unused_ok = ^{clk, rst, take};

   always_comb begin
      gnt = (i_req && !d_req) ? REQ_I : REQ_D;
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch and data load/store.
// Define MEM_ARB_RR_EN for round-robin arbitration on simultaneous requests.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned LATENCY = 4
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);

   state_t            state;
   state_t            state_nx;
   logic [CNT_W-1:0]  cnt;
   logic              gnt;
   logic              gnt_q;
   logic              wr_q;
   logic              take;
   logic              last_beat;
   logic [ADDR_W-1:0] addr_sel;
   logic [DATA_W-1:0] wdata_sel;

   mem_arb_grant u_grant (
      .clk   (clk),
      .rst   (rst),
      .i_req (bus.i_req),
      .d_req (bus.d_req),
      .take  (take),
      .gnt   (gnt)
   );

   always_comb begin
      state_nx  = state;
      take      = 1'b0;
      last_beat = 1'b0;
      addr_sel  = bus.i_addr;
      wdata_sel = '0;
      if (gnt == REQ_D) begin
         addr_sel  = bus.d_addr;
         wdata_sel = bus.d_wdata;
      end
      case (state)
         IDLE: begin
            if (bus.i_req || bus.d_req) begin
               take     = 1'b1;
               state_nx = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt == '0) begin
               last_beat = 1'b1;
               state_nx  = RESP;
            end
         end
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Memory drive is registered at grant so address/data/write stay flat
   // for the whole window; ready is registered so it lands in RESP.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt            <= '0;
         gnt_q          <= REQ_I;
         wr_q           <= 1'b0;
         bus.mem_addr   <= '0;
         bus.mem_wdata  <= '0;
         bus.mem_enable <= 1'b0;
         bus.mem_wr     <= 1'b0;
         bus.i_ready    <= 1'b0;
         bus.d_ready    <= 1'b0;
         bus.i_data     <= '0;
         bus.d_rdata    <= '0;
      end else begin
         bus.i_ready <= 1'b0;
         bus.d_ready <= 1'b0;
         if (take) begin
            gnt_q          <= gnt;
            wr_q           <= (gnt == REQ_D) && bus.d_wr;
            bus.mem_addr   <= addr_sel;
            bus.mem_wdata  <= wdata_sel;
            bus.mem_enable <= 1'b1;
            bus.mem_wr     <= (gnt == REQ_D) && bus.d_wr;
            cnt            <= CNT_W'(LATENCY - 1);
         end else if (state == ACCESS && !last_beat) begin
            cnt <= cnt - CNT_W'(1);
         end
         if (last_beat) begin
            bus.mem_enable <= 1'b0;
            bus.mem_wr     <= 1'b0;
            if (gnt_q == REQ_D) begin
               bus.d_ready <= 1'b1;
               if (!wr_q) begin
                  bus.d_rdata <= bus.mem_rdata;
               end
            end else begin
               bus.i_ready <= 1'b1;
               if (!wr_q) begin
                  bus.i_data <= bus.mem_rdata;
               end
            end
         end
      end
   end

   assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: per-cycle timeline model plus directed literal checks.
module tb_mem_arbiter;

   localparam int L = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   bit   model_on = 1'b0;

   mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();
   mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();

   mem_arbiter #(.ADDR_W(16), .DATA_W(16), .LATENCY(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   mem_arbiter #(.ADDR_W(16), .DATA_W(16), .LATENCY(1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic [15:0] mem     [0:65535];
   logic [15:0] ref_mem [0:65535];

   always @(posedge clk) begin
      if (bus.mem_enable && bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
   end
   assign bus.mem_rdata  = mem[bus.mem_addr];
   assign bus1.mem_rdata = bus1.mem_addr ^ 16'h5A5A;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s @cycle %0d: got %h, want %h", name, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Timeline model: a grant taken in idle cycle g owns cycles g+1..g+L+1.
   bit          m_active = 1'b0;
   int          m_g = 0;
   bit          m_side = 1'b0;
   bit          m_wr = 1'b0;
   bit          m_last = 1'b0;
   logic [15:0] m_addr = '0;
   logic [15:0] m_wdata = '0;
   logic [15:0] e_idata = '0;
   logic [15:0] e_drdata = '0;

   always @(negedge clk) begin
      if (model_on) begin
         automatic int c       = cyc;
         automatic bit in_acc  = m_active && (c > m_g) && (c <= m_g + L);
         automatic bit in_resp = m_active && (c == m_g + L + 1);
         automatic bit idle    = !m_active || (c >= m_g + L + 2);
         if (in_resp) begin
            if (m_wr) ref_mem[m_addr] = m_wdata;
            else if (m_side) e_drdata = ref_mem[m_addr];
            else e_idata = ref_mem[m_addr];
         end
         check("busy", bus.busy, in_acc || in_resp);
         check("mem_enable", bus.mem_enable, in_acc);
         check("mem_wr", bus.mem_wr, in_acc && m_wr);
         if (in_acc) check("mem_addr", bus.mem_addr, m_addr);
         if (in_acc && m_wr) check("mem_wdata", bus.mem_wdata, m_wdata);
         check("i_ready", bus.i_ready, in_resp && !m_side);
         check("d_ready", bus.d_ready, in_resp && m_side);
         check("i_data", bus.i_data, e_idata);
         check("d_rdata", bus.d_rdata, e_drdata);
         if (rst) begin
            m_active = 1'b0;
            m_last   = 1'b0;
            e_idata  = '0;
            e_drdata = '0;
         end else if (idle && (bus.i_req || bus.d_req)) begin
`ifdef MEM_ARB_RR_EN
            if (bus.i_req && bus.d_req) m_side = !m_last;
            else m_side = bus.d_req;
            m_last = m_side;
`else
            m_side = bus.d_req;
`endif
            m_active = 1'b1;
            m_g      = c;
            m_wr     = m_side && bus.d_wr;
            m_addr   = m_side ? bus.d_addr : bus.i_addr;
            m_wdata  = bus.d_wdata;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no $finish, want completion");
      $fatal(1);
   end

   initial begin
      int ni;
      int nd;
      bit tie2_i;
      bus.i_req = 0;  bus.i_addr = '0; bus.d_req = 0; bus.d_wr = 0;
      bus.d_addr = '0; bus.d_wdata = '0;
      bus1.i_req = 0; bus1.i_addr = '0; bus1.d_req = 0; bus1.d_wr = 0;
      bus1.d_addr = '0; bus1.d_wdata = '0;
      for (int a = 0; a < 65536; a++) begin
         mem[a]     = 16'(a * 3);
         ref_mem[a] = 16'(a * 3);
      end
      mem[16'h0010]     = 16'hABCD;
      ref_mem[16'h0010] = 16'hABCD;

      rst = 1'b1;
      tick();
      tick();
      model_on = 1'b1;
      @(negedge clk);
      check("rst_busy", bus.busy, 0);
      check("rst_en", bus.mem_enable, 0);
      check("rst_addr", bus.mem_addr, 0);
      check("rst_idata", bus.i_data, 0);
      check("rst1_en", bus1.mem_enable, 0);
      tick();
      rst = 1'b0;

      // Fetch alone
      bus.i_req = 1; bus.i_addr = 16'h0010;
      for (int k = 0; k <= 6; k++) begin
         @(negedge clk);
         check("fetch_en", bus.mem_enable, (k >= 1 && k <= 4));
         if (k >= 1 && k <= 4) check("fetch_addr", bus.mem_addr, 16'h0010);
         check("fetch_irdy", bus.i_ready, k == 5);
         check("fetch_drdy", bus.d_ready, 0);
         if (k == 5) check("fetch_data", bus.i_data, 16'hABCD);
         tick();
         if (k == 5) bus.i_req = 0;
      end

      // Store then load
      bus.d_req = 1; bus.d_wr = 1; bus.d_addr = 16'h0200; bus.d_wdata = 16'h1234;
      for (int k = 0; k <= 6; k++) begin
         @(negedge clk);
         check("st_wr", bus.mem_wr, (k >= 1 && k <= 4));
         check("st_drdy", bus.d_ready, k == 5);
         check("st_irdy", bus.i_ready, 0);
         tick();
         if (k == 5) begin bus.d_req = 0; bus.d_wr = 0; bus.d_wdata = 16'hFFFF; end
      end
      bus.d_req = 1; bus.d_addr = 16'h0200;
      for (int k = 0; k <= 6; k++) begin
         @(negedge clk);
         check("ld_drdy", bus.d_ready, k == 5);
         if (k == 5) check("ld_data", bus.d_rdata, 16'h1234);
         tick();
         if (k == 5) bus.d_req = 0;
      end

      // Ties: reset pointer, then both request; D keeps requesting once more
      rst = 1'b1;
      tick();
      rst = 1'b0;
`ifdef MEM_ARB_RR_EN
      tie2_i = 1'b1;
`else
      tie2_i = 1'b0;
`endif
      bus.i_req = 1; bus.i_addr = 16'h0021;
      bus.d_req = 1; bus.d_wr = 0; bus.d_addr = 16'h0030;
      ni = 0; nd = 0;
      for (int k = 0; k <= 19; k++) begin
         @(negedge clk);
         if (k == 5) begin
            check("tie1_drdy", bus.d_ready, 1);
            check("tie1_irdy", bus.i_ready, 0);
         end
         if (k == 11) begin
            check("tie2_irdy", bus.i_ready, tie2_i);
            check("tie2_drdy", bus.d_ready, !tie2_i);
         end
         if (k == 17) begin
            check("tie3_irdy", bus.i_ready, !tie2_i);
            check("tie3_drdy", bus.d_ready, tie2_i);
         end
         if (bus.i_ready) ni++;
         if (bus.d_ready) nd++;
         tick();
         if (ni >= 1) bus.i_req = 0;
         if (nd >= 2) bus.d_req = 0;
      end
      check("tie_ni", ni, 1);
      check("tie_nd", nd, 2);

      // Reset mid-access
      bus.i_req = 1; bus.i_addr = 16'h0044;
      for (int k = 0; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1 || k == 2) check("rma_en_on", bus.mem_enable, 1);
         if (k >= 3) begin
            check("rma_en_off", bus.mem_enable, 0);
            check("rma_busy", bus.busy, 0);
         end
         check("rma_irdy", bus.i_ready, 0);
         check("rma_drdy", bus.d_ready, 0);
         tick();
         if (k == 1) begin rst = 1'b1; bus.i_req = 0; end
         if (k == 2) rst = 1'b0;
      end

      // Held fetch request
      bus.i_req = 1; bus.i_addr = 16'h0010;
      for (int k = 0; k <= 18; k++) begin
         @(negedge clk);
         check("held_irdy", bus.i_ready, (k == 5 || k == 11 || k == 17));
         tick();
         if (k == 17) bus.i_req = 0;
      end

      // LATENCY=1 instance
      bus1.i_req = 1; bus1.i_addr = 16'h0033;
      for (int k = 0; k <= 3; k++) begin
         @(negedge clk);
         check("lat1_en", bus1.mem_enable, k == 1);
         check("lat1_irdy", bus1.i_ready, k == 2);
         if (k == 2) check("lat1_data", bus1.i_data, 16'h5A69);
         tick();
         if (k == 2) bus1.i_req = 0;
      end

      tick();
      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
